// File: rtl/fab_clk_div_gen.sv
// Multi-channel fabric clock divider.
// Each channel produces a one-cycle TICK every N = div+1 cycles and a
// registered square wave of period 2N. Divide values are staged in a shadow
// register and only take effect at a terminal count (or at once while the
// channel is idle), so a running channel never emits a short or long period.
// All channels wait for a fixed startup delay after reset before running.
module fab_clk_div_gen #(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 16,
  parameter int DEF_DIV        = 24999,
  parameter int STARTUP_CYCLES = 256,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic              ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  logic [SU_W-1:0] su_cnt_reg;
  logic            ready_reg;
  logic            ack_reg;
  logic            err_reg;
  logic            ch_valid;

  // An index outside the populated channel range is rejected, not aliased.
  assign ch_valid = (32'(div_ch) < 32'(NUM_CH));

  // Startup delay: count to STARTUP_CYCLES-1, then hold ready until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      su_cnt_reg <= '0;
      ready_reg  <= 1'b0;
    end else if (!ready_reg) begin
      if (su_cnt_reg == SU_W'(STARTUP_CYCLES - 1)) begin
        ready_reg <= 1'b1;
      end else begin
        su_cnt_reg <= su_cnt_reg + 1'b1;
      end
    end
  end

  // Load handshake: one-cycle accept or reject pulse after each request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      ack_reg <= div_load & ch_valid;
      err_reg <= div_load & ~ch_valid;
    end
  end

  assign ready   = ready_reg;
  assign div_ack = ack_reg;
  assign div_err = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg;
      logic [DIV_W-1:0] div_act_reg;
      logic [DIV_W-1:0] div_shadow_reg;
      logic             pending_reg;
      logic             tick_reg;
      logic             clk_out_reg;
      logic             active;
      logic             load_hit;

      assign active   = en[gi] & ready_reg;
      assign load_hit = div_load && (32'(div_ch) == 32'(gi));

      // Divider channel: terminal-count reload, pending ratio swap, and
      // staging of new loads. The load is evaluated after the swap so a load
      // landing on a terminal count waits for the following one.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg        <= '0;
          div_act_reg    <= DIV_W'(DEF_DIV);
          div_shadow_reg <= DIV_W'(DEF_DIV);
          pending_reg    <= 1'b0;
          tick_reg       <= 1'b0;
          clk_out_reg    <= 1'b0;
        end else begin
          if (active) begin
            if (cnt_reg == div_act_reg) begin
              cnt_reg     <= '0;
              tick_reg    <= 1'b1;
              clk_out_reg <= ~clk_out_reg;
              if (pending_reg) begin
                div_act_reg <= div_shadow_reg;
                pending_reg <= 1'b0;
              end
            end else begin
              cnt_reg  <= cnt_reg + 1'b1;
              tick_reg <= 1'b0;
            end
          end else begin
            // Idle channel: no period in flight, so a staged ratio is safe
            // to adopt straight away.
            cnt_reg     <= '0;
            tick_reg    <= 1'b0;
            clk_out_reg <= 1'b0;
            if (pending_reg) begin
              div_act_reg <= div_shadow_reg;
              pending_reg <= 1'b0;
            end
          end
          if (load_hit) begin
            div_shadow_reg <= div_val;
            pending_reg    <= 1'b1;
          end
        end
      end

      assign tick[gi]    = tick_reg;
      assign clk_out[gi] = clk_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fab_clk_div_gen.sv
// Bench for fab_clk_div_gen: directed scenarios followed by a randomized run,
// every cycle compared against an event-time reference model (each running
// channel tracks the absolute cycle of its next tick rather than a counter).
module tb_fab_clk_div_gen;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int DEF_DIV = 4;
  localparam int SU     = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              div_load;
  logic [CH_W-1:0]   div_ch;
  logic [DIV_W-1:0]  div_val;
  logic              div_ack;
  logic              div_err;
  logic              ready;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  fab_clk_div_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV),
    .STARTUP_CYCLES(SU), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .div_load(div_load), .div_ch(div_ch),
    .div_val(div_val), .div_ack(div_ack), .div_err(div_err), .ready(ready),
    .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int edge_no;
  int since_rst;
  int ratio [NUM_CH];
  int staged [NUM_CH];
  bit has_staged [NUM_CH];
  bit running [NUM_CH];
  int next_tick [NUM_CH];
  logic [NUM_CH-1:0] tick_m;
  logic [NUM_CH-1:0] clk_m;
  logic ack_m, err_m;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp_v, edge_no);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy_prev;
    edge_no++;
    if (reset) begin
      since_rst = 0;
      ack_m = 1'b0;
      err_m = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        running[i] = 1'b0;
        tick_m[i] = 1'b0;
        clk_m[i] = 1'b0;
        ratio[i] = DEF_DIV + 1;
        has_staged[i] = 1'b0;
      end
    end else begin
      rdy_prev = (since_rst >= SU);
      if (since_rst < SU) since_rst++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (en[i] && rdy_prev) begin
          if (!running[i]) begin
            running[i] = 1'b1;
            next_tick[i] = edge_no + ratio[i] - 1;
          end
          tick_m[i] = (edge_no == next_tick[i]);
          if (tick_m[i]) begin
            clk_m[i] = ~clk_m[i];
            if (has_staged[i]) ratio[i] = staged[i];
            has_staged[i] = 1'b0;
            next_tick[i] = edge_no + ratio[i];
          end
        end else begin
          running[i] = 1'b0;
          tick_m[i] = 1'b0;
          clk_m[i] = 1'b0;
          if (has_staged[i]) ratio[i] = staged[i];
          has_staged[i] = 1'b0;
        end
      end
      ack_m = div_load && (int'(div_ch) < NUM_CH);
      err_m = div_load && !(int'(div_ch) < NUM_CH);
      if (ack_m) begin
        staged[div_ch] = int'(div_val) + 1;
        has_staged[div_ch] = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(since_rst >= SU));
    chk("tick", 32'(tick), 32'(tick_m));
    chk("clk_out", 32'(clk_out), 32'(clk_m));
    chk("div_ack", 32'(div_ack), 32'(ack_m));
    chk("div_err", 32'(div_err), 32'(err_m));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // One-cycle load request.
  task automatic load(input int ch, input int val);
    div_load = 1'b1;
    div_ch = CH_W'(ch);
    div_val = DIV_W'(val);
    step();
    div_load = 1'b0;
  endtask

  initial begin
    bit found;
    edge_no = 0;
    since_rst = 0;
    reset = 1'b1;
    en = '1;
    div_load = 1'b0;
    div_ch = '0;
    div_val = '0;
    tick_m = '0;
    clk_m = '0;
    ack_m = 1'b0;
    err_m = 1'b0;

    // Reset state, with a load and enables asserted alongside reset.
    div_load = 1'b1;
    run(3);
    div_load = 1'b0;
    chk("reset_outputs", 32'({ready, tick, clk_out, div_ack, div_err}), 32'd0);

    // Startup delay with all channels enabled, then steady N=5.
    reset = 1'b0;
    run(SU - 1);
    chk("ready_before_delay", 32'(ready), 32'd0);
    step();
    chk("ready_after_delay", 32'(ready), 32'd1);
    run(25);

    // Live change on ch0 mid-period to N=2.
    run(2);
    load(0, 1);
    chk("live_ack", 32'(div_ack), 32'd1);
    run(20);

    // Boundaries: N=1 on ch2, invalid channel index.
    load(2, 0);
    run(10);
    load(3, 7);
    chk("invalid_err", 32'(div_err), 32'd1);
    chk("invalid_no_ack", 32'(div_ack), 32'd0);
    run(6);

    // Load landing exactly on ch1's terminal count.
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (running[1] && next_tick[1] == edge_no + 1) found = 1'b1;
      else step();
    end
    chk("find_terminal", 32'(found), 32'd1);
    load(1, 2);
    chk("tc_tick", 32'(tick[1]), 32'd1);
    run(15);

    // EN[1] dropped for 3 cycles mid-period, with a load while disabled.
    run(1);
    en[1] = 1'b0;
    step();
    load(1, 3);
    step();
    chk("disabled_clk_out", 32'(clk_out[1]), 32'd0);
    en[1] = 1'b1;
    run(20);

    // Double load while pending: last value wins.
    load(0, 5);
    load(0, 2);
    run(15);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        div_load = 1'b1;
        div_ch = CH_W'($urandom_range(0, 3));
        div_val = DIV_W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      reset = ($urandom_range(0, 299) == 0);
      step();
      div_load = 1'b0;
      reset = 1'b0;
    end

    // Reset pulse mid-run.
    en = '1;
    run(SU + 12);
    reset = 1'b1;
    div_load = 1'b1;
    div_ch = '0;
    step();
    reset = 1'b0;
    div_load = 1'b0;
    chk("midrun_reset", 32'({ready, tick, clk_out, div_ack, div_err}), 32'd0);
    run(SU + 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
